stream_compactor: RTL
=====================

Name: stream_compactor

Overview:
- Receives element streams whose valid elements are packed at the low end of each beat, with `keep` as a prefix mask and a variable count per beat.
- Merges consecutive beats into dense output beats with all `NUM_ELEMENTS` valid; a partial beat appears only at packet end.
- It is the consumer-side counterpart of the normalization shifters: it computes a rotation from its own fill level and absorbs the rotated elements into an accumulator.
- It sits between the normalization stage and downstream fixed-width consumers.

Parameters:
- `data_t`, none: element type.
- `NUM_ELEMENTS`, 8: elements per beat. Must be a power of two, 2 or more.
- `COUNT_WIDTH`, `$clog2(NUM_ELEMENTS+1)`: width of element counts.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `in`  ndata_i.s  `data_t` x `NUM_ELEMENTS`, with `keep`/`last`/`valid`/`ready`  input stream. `keep` is a prefix mask: valid elements occupy indices 0..k-1, 0 ≤ k ≤ N.
- `out`  ndata_i.m  same shape  output stream. `keep` is all-ones except on a final partial beat, which carries a prefix mask.
- `fill_level`  output  `COUNT_WIDTH`  current accumulator occupancy, 0..N-1; for debug and verification.

Behaviour:
- State: accumulator `acc[N]`, fill `f` (0..N-1), `fsm` ∈ {RUN, FLUSH}, a single registered output stage, and a remainder register `rem`/`rem_cnt` used in FLUSH.
- Reset (`rst`=1 at posedge):
  - `out.valid`=0, `f`=0, `fsm`=RUN, `rem_cnt`=0.
  - `out.data`/`out.keep`/`out.last` are don't-care; `out.keep` and `out.last` reset to 0.
  - Reset mid-packet discards all buffered elements; the next accepted beat starts at element 0.
- Readiness: `in.ready` = (`fsm`==RUN) && (!`out.valid` || `out.ready`). A beat is accepted when `in.valid` && `in.ready`.
- Output stage: advances when `out.ready` || !`out.valid`. `out.valid` drops the cycle after a handshake if nothing new is loaded. While stalled, `out` holds stable.
- Accepted beat, k = popcount(`in.keep`). Rotate input left by `f`: element i goes to position (i+f) mod N. Let s = f+k.
  - s < N, not last: write rotated positions f..s-1 into `acc`; `f` ← s; no output.
  - s ≥ N, not last: output beat = `acc` positions 0..f-1 plus rotated positions f..N-1; `keep` all-ones; `last`=0. Remaining rotated positions 0..s-N-1 go into `acc`; `f` ← s-N.
  - last, s ≤ N: output beat = merge; `keep` = low s bits set; `last`=1; `f` ← 0. If s=0, a beat with `keep`=0 and `last`=1 is still emitted.
  - last, s > N: emit the full beat with `last`=0. Store the remainder (s-N elements) in `rem`; `fsm` ← FLUSH.
- FLUSH:
  - `in.ready`=0.
  - When the output stage advances, load `rem` with `keep` = low (s-N) bits and `last`=1; `f` ← 0; `fsm` ← RUN.
- Latency: 1 cycle from the accepting edge to `out.valid`. Sustained throughput is 1 beat/cycle with `out.ready`=1, except one bubble per packet whose last beat overflows (the FLUSH cycle).
- Simultaneous events: an output handshake and a new input acceptance occur in the same cycle without a bubble. `rst` dominates everything.
- Arithmetic: s is computed at `COUNT_WIDTH`+1 bits; no wrap-around. `fill_level` = `f`.
- A non-prefix `keep` is illegal. A simulation assertion fires; the hardware result is undefined.

Test Plan (N=4, element values = sequence index):
1. Four beats with k=3 each, carrying 0..11, `last` on the 4th → output [0,1,2,3], [4,5,6,7], [8,9,10,11], `keep`=1111 on all, `last` only on the third. `fill_level` sequence is 3,2,1,0.
2. Two beats with k=3 (0..5), `last` on the 2nd → [0,1,2,3] `last`=0, then [4,5,x,x] `keep`=0011 `last`=1. `in.ready` is low exactly one cycle (FLUSH).
3. Last beat with k=0 at f=0 → one beat, `keep`=0000, `last`=1. Same at f=1 holding element 7 → [7,x,x,x], `keep`=0001, `last`=1.
4. Continuous k=4 beats with `out.ready`=1 → one output per cycle, 1-cycle latency, data unchanged, `f` stays 0.
5. `out.ready` held low for 5 cycles with a beat pending → `out.data`/`out.keep`/`out.last` stable, `in.ready`=0, no element lost or duplicated after release.
6. `rst` asserted at f=2 mid-packet → next cycle `out.valid`=0 and `fill_level`=0. A following beat [20,21,22,23] k=4 `last` → output [20,21,22,23], `last`=1.

Source files
------------

// File: rtl/stream_compactor_if.sv
// rtl/stream_compactor_if.sv - element-vector stream with prefix keep mask
interface ndata_i #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 8
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/stream_compactor.sv
// rtl/stream_compactor.sv - packs prefix-masked beats into dense full-width beats
module stream_compactor #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 8,
  parameter int  COUNT_WIDTH  = $clog2(NUM_ELEMENTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  ndata_i.s                      in,
  ndata_i.m                      out,
  output logic [COUNT_WIDTH-1:0] fill_level
);
  localparam int N = NUM_ELEMENTS;
  localparam int IDX_WIDTH = $clog2(NUM_ELEMENTS);
  localparam logic [COUNT_WIDTH:0] N_S = (COUNT_WIDTH + 1)'(NUM_ELEMENTS);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state, nxt_state;
  data_t [N-1:0]          acc, nxt_acc, rem, nxt_rem, rot, merged;
  data_t [N-1:0]          out_data, nxt_out_data;
  logic  [N-1:0]          out_keep, nxt_out_keep, keep_inc;
  logic                   out_last, nxt_out_last, out_valid, nxt_out_valid;
  logic [COUNT_WIDTH-1:0] f, nxt_f, rem_cnt, nxt_rem_cnt, k;
  logic [COUNT_WIDTH:0]   s;
  logic                   in_ready, adv, accept;

  function automatic logic [N-1:0] prefix_mask(input logic [COUNT_WIDTH:0] cnt);
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) m[j] = ((COUNT_WIDTH + 1)'(j) < cnt);
    return m;
  endfunction

  assign adv      = out.ready || !out_valid;
  assign in_ready = (state == RUN) && adv;
  assign accept   = in.valid && in_ready;

  assign in.ready   = in_ready;
  assign out.valid  = out_valid;
  assign out.data   = out_data;
  assign out.keep   = out_keep;
  assign out.last   = out_last;
  assign fill_level = f;

  // Input is rotated so its element 0 lands at the first free accumulator slot.
  always_comb begin
    k = '0;
    for (int j = 0; j < N; j++) k = k + COUNT_WIDTH'(in.keep[j]);
    s = {1'b0, f} + {1'b0, k};
    for (int j = 0; j < N; j++) begin
      rot[j]    = in.data[IDX_WIDTH'(j) - f[IDX_WIDTH-1:0]];
      merged[j] = (COUNT_WIDTH'(j) < f) ? acc[j] : rot[j];
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_f         = f;
    nxt_acc       = acc;
    nxt_rem       = rem;
    nxt_rem_cnt   = rem_cnt;
    nxt_out_valid = out_valid;
    nxt_out_data  = out_data;
    nxt_out_keep  = out_keep;
    nxt_out_last  = out_last;
    if (adv) nxt_out_valid = 1'b0;

    case (state)
      RUN: if (accept) begin
        if (s < N_S) begin
          if (in.last) begin
            nxt_out_valid = 1'b1;
            nxt_out_data  = merged;
            nxt_out_keep  = prefix_mask(s);
            nxt_out_last  = 1'b1;
            nxt_f         = '0;
          end else begin
            for (int j = 0; j < N; j++)
              if (COUNT_WIDTH'(j) >= f) nxt_acc[j] = rot[j];
            nxt_f = COUNT_WIDTH'(s);
          end
        end else begin
          nxt_out_valid = 1'b1;
          nxt_out_data  = merged;
          nxt_out_keep  = '1;
          nxt_out_last  = 1'b0;
          if (!in.last) begin
            nxt_acc = rot;
            nxt_f   = COUNT_WIDTH'(s - N_S);
          end else if (s == N_S) begin
            nxt_out_last = 1'b1;
            nxt_f        = '0;
          end else begin
            // Overflowing last beat: spill the tail and emit it next cycle.
            nxt_rem     = rot;
            nxt_rem_cnt = COUNT_WIDTH'(s - N_S);
            nxt_f       = COUNT_WIDTH'(s - N_S);
            nxt_state   = FLUSH;
          end
        end
      end
      FLUSH: if (adv) begin
        nxt_out_valid = 1'b1;
        nxt_out_data  = rem;
        nxt_out_keep  = prefix_mask({1'b0, rem_cnt});
        nxt_out_last  = 1'b1;
        nxt_f         = '0;
        nxt_rem_cnt   = '0;
        nxt_state     = RUN;
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      f         <= '0;
      acc       <= '0;
      rem       <= '0;
      rem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= nxt_state;
      f         <= nxt_f;
      acc       <= nxt_acc;
      rem       <= nxt_rem;
      rem_cnt   <= nxt_rem_cnt;
      out_valid <= nxt_out_valid;
      out_data  <= nxt_out_data;
      out_keep  <= nxt_out_keep;
      out_last  <= nxt_out_last;
    end
  end

  assign keep_inc = in.keep + N'(1);

  a_keep_prefix: assert property (@(posedge clk) disable iff (rst)
    accept |-> ((in.keep & keep_inc) == '0));
endmodule
